map_bus_arbiter: RTL
====================

// Module: map_bus_arbiter
// PURPOSE
//  Shares one memory-mapped satellite register port (addr/wdata/wrEn/rdata) between two requesters:
//  the core load/store path (req 0) and the debug/programming port (req 1).
//  Serialises accesses, drives the map-block side for exactly one cycle per access and returns
//  registered read data with a one-cycle ack. Sits between the requesters and the map blocks.
// PARAMETERS
//  ADDR_W     4   map-port address width (word address)
//  DATA_W     16  data width
//  DBG_PRIO   1   1: debug wins simultaneous requests (subject to starvation guard); 0: pure round-robin
//  MAX_WAIT   7   cycles core may wait while debug is granted before core is forced next (1..15)
// PORTS
//  i_clk         in   1       clock, all state on rising edge
//  i_rstn        in   1       reset, asynchronous, active-low
//  i_coreReq     in   1       core access request; held with addr/data until i_coreAck
//  i_coreAddr    in   ADDR_W  core address
//  i_coreData    in   DATA_W  core write data
//  i_coreWr      in   1       1=write, 0=read
//  o_coreAck     out  1       one-cycle pulse: core access done
//  o_coreData    out  DATA_W  read data, valid while o_coreAck=1
//  i_dbgReq/i_dbgAddr/i_dbgData/i_dbgWr/o_dbgAck/o_dbgData   same as core set, debug requester
//  o_memAddr     out  ADDR_W  map-port address
//  o_memDataIn   out  DATA_W  map-port write data
//  o_memWrEn     out  1       map-port write strobe, one cycle per write
//  i_memDataOut  in   DATA_W  map-port read data (combinational from o_memAddr)
//  o_busy        out  1       1 when state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, lastGnt=core, waitCnt=0; all outputs 0 (o_memWrEn deasserts immediately).
//  FSM IDLE -> ISSUE -> ACK -> IDLE; no other states.
//   IDLE: if any req, select winner, latch sel/addr/data/wr into regs, go ISSUE; else stay.
//   ISSUE: o_memAddr/o_memDataIn = latched values; o_memWrEn = latched wr; capture
//          i_memDataOut into rdata reg (reads and writes alike); go ACK.
//   ACK: pulse ack of selected requester; its o_*Data = rdata reg; go IDLE.
//  Latency: req seen in IDLE at cycle N -> map access in N+1 -> ack in N+2. Min 3 cycles/access;
//   back-to-back same requester: next access starts in IDLE at N+3.
//  o_memAddr/o_memDataIn hold last latched values outside ISSUE; o_memWrEn is 0 outside ISSUE.
//  Non-selected requester's ack stays 0; o_*Data of a requester only change in its ACK cycle.
//  Arbitration (IDLE only, both requesting):
//   DBG_PRIO=1: debug wins unless waitCnt==MAX_WAIT, then core wins.
//   DBG_PRIO=0: grant the requester != lastGnt.
//   Single requester always wins. lastGnt updated on each grant.
//  waitCnt (4 bits): +1 per debug grant while i_coreReq=1; cleared on core grant or core idle
//   in IDLE; saturates at MAX_WAIT (never wraps).
//  Requests sampled only in IDLE; inputs changing in ISSUE/ACK are ignored (latched copy used).
//  Req withdrawn after grant: access still completes and ack still pulses (protocol violation
//   by requester, not an arbiter error). Req still high in ACK cycle is NOT a new request;
//   requester must see ack and may keep req high only if issuing a further access.
//  Async reset mid-ISSUE: write strobe dropped at once, access lost, no ack issued.
// STRUCTURE
//  Shared package: state encoding (IDLE=2'b00, ISSUE=2'b01, ACK=2'b10), requester id constants
//   (REQ_CORE=0, REQ_DBG=1).
//  One sub-module natural: map_arb_pick (comb winner select from reqs, lastGnt, waitCnt, DBG_PRIO).
//  Rest (FSM, latches, rdata reg, wait counter) in top; registers use async-reset flops.
// TESTING
//  Core write addr=1 data=16'h1234 alone -> o_memWrEn=1 exactly one cycle, addr=1, data=1234; coreAck 2 cycles after req.
//  Debug read addr=2, i_memDataOut=16'h0ABC in ISSUE -> dbgAck pulse, o_dbgData=0ABC; o_coreData unchanged.
//  Both req continuously, DBG_PRIO=1, MAX_WAIT=7 -> 7 debug grants then 1 core grant, repeating.
//  Both req, DBG_PRIO=0 -> grants alternate core/debug starting with debug (lastGnt=core at reset).
//  Drive i_rstn=0 during ISSUE of a write -> o_memWrEn falls same cycle, no ack, FSM IDLE, all outputs 0.
//  Core drops req in ISSUE cycle -> coreAck still pulses next cycle; no second access started.

Source files
------------

// File: rtl/map_bus_arbiter_pkg.sv
// Shared constants for the map-port arbiter: FSM state encoding, requester ids
// and the saturating wait-counter helper.
package map_bus_arbiter_pkg;

    localparam int WAIT_W = 4;

    // FSM encoding kept as plain constants so legacy code can compare raw bits.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ISSUE = 2'b01;
    localparam logic [1:0] ST_ACK   = 2'b10;

    // Requester ids, also used as the grant-select / last-grant encoding.
    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

    // Increment that sticks at the limit instead of wrapping.
    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] cnt,
                                                  input logic [WAIT_W-1:0] lim);
        return (cnt >= lim) ? lim : cnt + WAIT_W'(1);
    endfunction

endpackage

// File: rtl/map_arb_pick.sv
// Combinational winner selection for the map-port arbiter. Only meaningful
// while the arbiter is idle; the top decides when to act on the result.
module map_arb_pick
    import map_bus_arbiter_pkg::*;
#(
    parameter int DBG_PRIO = 1,
    parameter int MAX_WAIT = 7
)(
    input  logic              i_coreReq,
    input  logic              i_dbgReq,
    input  logic              i_lastGnt,
    input  logic [WAIT_W-1:0] i_waitCnt,
    output logic              o_gntValid,
    output logic              o_gntSel
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    // Pick the winner: a lone requester always wins, contention uses priority or round-robin.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_gntValid = i_coreReq | i_dbgReq;
        o_gntSel   = REQ_CORE;
        if (i_coreReq && i_dbgReq) begin
            if (DBG_PRIO != 0) begin
                // Debug is favoured until the core has waited long enough.
                o_gntSel = (i_waitCnt == MAX_WAIT_C) ? REQ_CORE : REQ_DBG;
            end else begin
                o_gntSel = (i_lastGnt == REQ_CORE) ? REQ_DBG : REQ_CORE;
            end
        end else if (i_dbgReq) begin
            o_gntSel = REQ_DBG;
        end
    end

endmodule

// File: rtl/map_bus_arbiter.sv
// Two-requester arbiter for the memory-mapped satellite register port.
// Each access runs IDLE -> ISSUE (one map-port cycle) -> ACK (one-cycle ack).
module map_bus_arbiter
    import map_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 16,
    parameter int DBG_PRIO = 1,
    parameter int MAX_WAIT = 7
)(
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_coreReq,
    input  logic [ADDR_W-1:0] i_coreAddr,
    input  logic [DATA_W-1:0] i_coreData,
    input  logic              i_coreWr,
    output logic              o_coreAck,
    output logic [DATA_W-1:0] o_coreData,
    input  logic              i_dbgReq,
    input  logic [ADDR_W-1:0] i_dbgAddr,
    input  logic [DATA_W-1:0] i_dbgData,
    input  logic              i_dbgWr,
    output logic              o_dbgAck,
    output logic [DATA_W-1:0] o_dbgData,
    output logic [ADDR_W-1:0] o_memAddr,
    output logic [DATA_W-1:0] o_memDataIn,
    output logic              o_memWrEn,
    input  logic [DATA_W-1:0] i_memDataOut,
    output logic              o_busy
);

    logic [1:0]        r_state;
    logic              r_sel;
    logic              r_lastGnt;
    logic              r_wr;
    logic [WAIT_W-1:0] r_waitCnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_coreData;
    logic [DATA_W-1:0] r_dbgData;

    logic              w_gntValid;
    logic              w_gntSel;
    logic [ADDR_W-1:0] w_reqAddr;
    logic [DATA_W-1:0] w_reqData;
    logic              w_reqWr;

    map_arb_pick #(
        .DBG_PRIO (DBG_PRIO),
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .i_coreReq  (i_coreReq),
        .i_dbgReq   (i_dbgReq),
        .i_lastGnt  (r_lastGnt),
        .i_waitCnt  (r_waitCnt),
        .o_gntValid (w_gntValid),
        .o_gntSel   (w_gntSel)
    );

    // Request fields of whichever requester is winning this cycle.
    assign w_reqAddr = (w_gntSel == REQ_DBG) ? i_dbgAddr : i_coreAddr;
    assign w_reqData = (w_gntSel == REQ_DBG) ? i_dbgData : i_coreData;
    assign w_reqWr   = (w_gntSel == REQ_DBG) ? i_dbgWr   : i_coreWr;

    // Access sequencer: latch the winner in IDLE, run the map access, return data in ACK.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= ST_IDLE;
            r_sel      <= REQ_CORE;
            r_lastGnt  <= REQ_CORE;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_coreData <= '0;
            r_dbgData  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            case (r_state)
                ST_IDLE: begin
                    if (w_gntValid) begin
                        r_sel     <= w_gntSel;
                        r_lastGnt <= w_gntSel;
                        r_addr    <= w_reqAddr;
                        r_data    <= w_reqData;
                        r_wr      <= w_reqWr;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Read data is captured for writes too; it lands only in the owner's register.
                    if (r_sel == REQ_CORE) begin
                        r_coreData <= i_memDataOut;
                    end else begin
                        r_dbgData <= i_memDataOut;
                    end
                    r_state <= ST_ACK;
                end
                ST_ACK:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Starvation guard: count debug grants that overtook a waiting core request.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_waitCnt <= '0;
        end else if (r_state == ST_IDLE) begin
            if (!i_coreReq || (w_gntSel == REQ_CORE)) begin
                r_waitCnt <= '0;
            end else begin
                r_waitCnt <= sat_inc(r_waitCnt, WAIT_W'(MAX_WAIT));
            end
        end
    end

    // NOTE: the strobe is decoded from the state flop, so an async reset drops it immediately.
    assign o_memWrEn   = (r_state == ST_ISSUE) && r_wr;
    assign o_memAddr   = r_addr;
    assign o_memDataIn = r_data;
    assign o_coreAck   = (r_state == ST_ACK) && (r_sel == REQ_CORE);
    assign o_dbgAck    = (r_state == ST_ACK) && (r_sel == REQ_DBG);
    assign o_coreData  = r_coreData;
    assign o_dbgData   = r_dbgData;
    assign o_busy      = (r_state != ST_IDLE);

endmodule
